// File: rtl/ripemd160_msg_feeder.sv
// RIPEMD-160 message feeder: buffers SHA-256 digests in a FIFO, pads each into
// one 512-bit little-endian block, and issues paced one-cycle block pulses.
//
// Parameters:
//   DEPTH         FIFO entries (power of two, >= 2)
//   CORE_LATENCY  cycles from an issue edge until the core is idle again
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       digest valid from the SHA-256 stage
//   in_ready       FIFO not full (combinational)
//   in_digest      256-bit digest, byte0 = in_digest[255:248]
//   core_done      core completion pulse (only with RIPEMD160_FEED_DONE_EN)
//   blk_valid      one-cycle issue pulse
//   blk_data       padded block, held until the next issue
//   busy           state != IDLE or FIFO non-empty
// Optional feature: define RIPEMD160_FEED_DONE_EN to pace on core_done
// instead of the fixed CORE_LATENCY counter.
module ripemd160_msg_feeder #(
    parameter int DEPTH        = 2,
    parameter int CORE_LATENCY = 84
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] in_digest,
`ifdef RIPEMD160_FEED_DONE_EN
    input  logic         core_done,
`endif
    output logic         blk_valid,
    output logic [511:0] blk_data,
    output logic         busy
);

    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNTW = $clog2(DEPTH + 1);
    localparam int LW   = $clog2(CORE_LATENCY + 1);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t         state_q, state_d;
    logic [LW-1:0]  cnt_q, cnt_d;
    logic           blk_valid_q, blk_valid_d;
    logic [511:0]   blk_data_q, blk_data_d;

    logic [255:0]   mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNTW-1:0] count_q;
    logic           push;
    logic           pop;

    // Byte b of the digest lands in bits [8b+7:8b], giving little-endian
    // words; then the 0x80 terminator and the 256-bit length.
    function automatic logic [511:0] pad(input logic [255:0] d);
        logic [511:0] b;
        b = '0;
        for (int i = 0; i < 32; i++) begin
            b[8*i +: 8] = d[255-8*i -: 8];
        end
        b[256 +: 32] = 32'h0000_0080;
        b[448 +: 32] = 32'h0000_0100;
        return b;
    endfunction

    assign in_ready = (count_q != CNTW'(DEPTH));
    assign push     = in_valid & in_ready;

    // FIFO storage; contents need no reset, occupancy is tracked by count_q
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_digest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNTW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            blk_valid_q <= 1'b0;
            blk_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            blk_valid_q <= blk_valid_d;
            blk_data_q  <= blk_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        blk_valid_d = 1'b0;
        blk_data_d  = blk_data_q;
        pop         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    blk_data_d  = pad(mem_q[rd_ptr_q]);
                    blk_valid_d = 1'b1;
                    pop         = 1'b1;
                    cnt_d       = LW'(CORE_LATENCY - 1);
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - LW'(1);
                end
`ifdef RIPEMD160_FEED_DONE_EN
                if (core_done) begin
                    state_d = IDLE;
                end
`else
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign blk_valid = blk_valid_q;
    assign blk_data  = blk_data_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_ripemd160_msg_feeder.sv
// Self-checking bench for ripemd160_msg_feeder: vector table, scoreboard of
// expected blocks, and sequences for pacing, back-pressure and reset.
module tb_ripemd160_msg_feeder;

    localparam int LAT = 84;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [255:0] in_digest = '0;
    logic         in_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         busy;
`ifdef RIPEMD160_FEED_DONE_EN
    logic         core_done = 1'b0;
    bit           auto_done = 1'b1;
    int           done_at = -1;
`endif

    ripemd160_msg_feeder #(.DEPTH(2), .CORE_LATENCY(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_digest (in_digest),
`ifdef RIPEMD160_FEED_DONE_EN
        .core_done (core_done),
`endif
        .blk_valid (blk_valid),
        .blk_data  (blk_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [511:0] sbq[$];
    int npulse = 0;
    int last_t = 0;
    int prev_t = 0;
    logic prev_v = 1'b0;

    typedef struct {
        logic [255:0] dig;
        logic [31:0]  w0;
        logic [31:0]  w7;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] act,
                       input logic [511:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s timed out", nm);
    endtask

    function automatic logic [7:0] bt(input logic [255:0] d, input int b);
        return d[255-8*b -: 8];
    endfunction

    function automatic logic [511:0] ref_block(input logic [255:0] d);
        logic [511:0] r;
        r = '0;
        for (int j = 0; j < 8; j++) begin
            r[32*j +: 32] = {bt(d, 4*j+3), bt(d, 4*j+2),
                             bt(d, 4*j+1), bt(d, 4*j)};
        end
        r[256 +: 32] = 32'h0000_0080;
        r[448 +: 32] = 32'h0000_0100;
        return r;
    endfunction

    // Monitor: scoreboard compare, pulse width, pulse timestamps
    always @(negedge clk) begin
        if (prev_v) chk("pulse_width", {511'b0, blk_valid}, 512'b0);
        if (blk_valid) begin
            if (sbq.size() == 0) begin
                timeout("unexpected_pulse (no expected block queued)");
            end else begin
                chk("sb_block", blk_data, sbq.pop_front());
            end
            prev_t = last_t;
            last_t = cyc;
            npulse++;
        end
        prev_v = blk_valid;
    end

`ifdef RIPEMD160_FEED_DONE_EN
    // Simple core model: completes LAT cycles after each issue
    always @(negedge clk) begin
        if (auto_done) begin
            core_done = 1'b0;
            if (blk_valid) done_at = cyc + LAT - 1;
            if (cyc == done_at) core_done = 1'b1;
        end
    end
`endif

    task automatic push(input logic [255:0] d);
        int t;
        t = 0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_digest = d;
        while (!in_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            timeout("push_ready");
            in_valid = 1'b0;
        end else begin
            sbq.push_back(ref_block(d));
            @(posedge clk);
            #1;
            in_valid  = 1'b0;
            in_digest = {8{32'hdead_beef}};
        end
    endtask

    task automatic wait_pulses(input int n, input int budget);
        int t;
        t = 0;
        while (npulse < n && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (npulse < n) timeout("wait_pulse");
    endtask

    task automatic wait_idle(input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (busy) timeout("wait_idle");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[5];
        logic [511:0] rest;
        logic [255:0] da;
        int base;
        int pc;
        int t1;
        int np;

        tv[0] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  32'h03020100, 32'h1f1e1d1c};
        tv[1] = '{{256{1'b1}}, 32'hffffffff, 32'hffffffff};
        tv[2] = '{256'h0, 32'h0, 32'h0};
        tv[3] = '{{32'hdeadbeef, 224'h0}, 32'hefbeadde, 32'h0};
        tv[4] = '{{224'h0, 32'hcafef00d}, 32'h0, 32'h0df0feca};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_blk_valid", {511'b0, blk_valid}, 512'b0);
        chk("rst_blk_data", blk_data, 512'b0);
        chk("rst_busy", {511'b0, busy}, 512'b0);
        chk("rst_in_ready", {511'b0, in_ready}, 512'b1);
        rst_n = 1'b1;

        // Vector table: padding and single-push latency
        for (int i = 0; i < 5; i++) begin
            base = npulse;
            push(tv[i].dig);
            pc = cyc;
            wait_pulses(base + 1, 20);
            chk_i("latency", last_t - pc, 1);
            chk("word0", {480'b0, blk_data[31:0]}, {480'b0, tv[i].w0});
            chk("word7", {480'b0, blk_data[255:224]}, {480'b0, tv[i].w7});
            chk("word8", {480'b0, blk_data[287:256]}, 512'h80);
            chk("word14", {480'b0, blk_data[479:448]}, 512'h100);
            rest = blk_data;
            rest[287:0]   = '0;
            rest[479:448] = '0;
            chk("zero_words", rest, 512'b0);
            wait_idle(200);
        end

        // Three consecutive pushes into DEPTH=2
        base = npulse;
        push(tv[0].dig);
        push(tv[3].dig);
        push(tv[4].dig);
        chk("full_ready", {511'b0, in_ready}, 512'b0);
        chk("full_busy", {511'b0, busy}, 512'b1);
        wait_pulses(base + 2, 200);
        chk_i("spacing_1_2", last_t - prev_t, LAT + 1);
        chk("ready_after_pop", {511'b0, in_ready}, 512'b1);
        wait_pulses(base + 3, 200);
        chk_i("spacing_2_3", last_t - prev_t, LAT + 1);
        wait_idle(200);

        // Push during WAIT: no early pulse, data held meanwhile
        base = npulse;
        da = tv[1].dig;
        push(da);
        wait_pulses(base + 1, 20);
        t1 = last_t;
        repeat (30) @(negedge clk);
        chk("blk_data_held", blk_data, ref_block(da));
        push(tv[3].dig);
        chk("busy_wait", {511'b0, busy}, 512'b1);
        wait_pulses(base + 2, 200);
        chk_i("no_early_pulse", last_t - t1, LAT + 1);
        wait_idle(200);

        // Reset mid-WAIT with one entry buffered
        base = npulse;
        push(tv[0].dig);
        wait_pulses(base + 1, 20);
        push(tv[1].dig);
        repeat (8) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_blk_valid", {511'b0, blk_valid}, 512'b0);
        chk("mid_rst_blk_data", blk_data, 512'b0);
        chk("mid_rst_busy", {511'b0, busy}, 512'b0);
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        np = npulse;
        repeat (200) @(negedge clk);
        chk_i("no_pulse_after_reset", npulse, np);
        push(tv[4].dig);
        wait_pulses(np + 1, 20);
        wait_idle(200);

`ifdef RIPEMD160_FEED_DONE_EN
        // core_done releases WAIT early
        auto_done = 1'b0;
        core_done = 1'b0;
        base = npulse;
        push(tv[0].dig);
        push(tv[1].dig);
        wait_pulses(base + 1, 20);
        repeat (19) @(negedge clk);
        core_done = 1'b1;
        pc = cyc;
        @(negedge clk);
        core_done = 1'b0;
        wait_pulses(base + 2, 20);
        chk_i("done_to_issue", last_t - pc, 2);
        @(negedge clk);
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        auto_done = 1'b1;
        wait_idle(200);
`endif

        chk_i("sb_drained", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
